mem_replay_pipe: RTL and testbench

Parametrised replay delay line for the memory issue path. It captures every packet issued to the memory pipe and re-presents it DEPTH cycles later for replay, tracking per-packet replay attempts. It applies branch/ROB kills to every stage on every cycle and freezes under the memory-side stall conditions. It sits between the memory issue queue select stage and the replay mux in front of the AGU.

---
 rtl/mem_replay_pipe_pkg.sv | 58 +++++
 rtl/mem_replay_stage.sv | 40 ++++
 rtl/mem_replay_pipe.sv | 103 ++++++++++
 tb/tb_mem_replay_pipe.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_replay_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_replay_pipe_pkg
// Description : Shared types for the memory replay delay line: flush
//               broadcast, memory dispatch packet, replay stage record.
// Revision    : 1.0
// ============================================================================
package mem_replay_pipe_pkg;

    localparam int ROB_TAG_W    = 4;
    localparam int ROB_SIZE     = 1 << ROB_TAG_W;
    localparam int REPLAY_CNT_W = 3;

    typedef struct packed {
        logic                valid;
        logic [ROB_SIZE-1:0] kill_mask;
    } branch_flush_t;

    typedef enum logic [1:0] {
        MEM_OP_LOAD  = 2'd0,
        MEM_OP_STORE = 2'd1,
        MEM_OP_AMO   = 2'd2,
        MEM_OP_FENCE = 2'd3
    } mem_op_e;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] rob_tag;
        mem_op_e              op;
        logic [4:0]           prd;
        logic [15:0]          imm;
    } mem_dispatch_pack_t;

    typedef struct packed {
        logic                    valid;
        logic [REPLAY_CNT_W-1:0] cnt;
        mem_dispatch_pack_t      pack;
    } replay_stage_t;

    function automatic logic IsBrROBKill(input branch_flush_t f,
                                         input logic [ROB_TAG_W-1:0] tag);
        return f.valid & f.kill_mask[tag];
    endfunction

    // Saturating attempt counter: a fresh issue starts at zero.
    function automatic logic [REPLAY_CNT_W-1:0] next_replay_cnt(
        input logic                    is_replay,
        input logic [REPLAY_CNT_W-1:0] cnt
    );
        if (!is_replay)
            return '0;
        else if (&cnt)
            return cnt;
        else
            return cnt + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_replay_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_replay_stage
// Description : One replay delay stage: loads when not held, otherwise holds
//               its payload and only drops valid on a kill.
// Revision    : 1.0
// ============================================================================
module mem_replay_stage
    import mem_replay_pipe_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  branch_flush_t           i_flush,
    input  logic                    i_hold,
    input  logic                    i_load_valid,
    input  logic [REPLAY_CNT_W-1:0] i_load_cnt,
    input  mem_dispatch_pack_t      i_load_pack,
    output replay_stage_t           o_stage
);

    replay_stage_t r_stage;
    logic          w_kill;

    assign w_kill  = IsBrROBKill(i_flush, r_stage.pack.rob_tag);
    assign o_stage = r_stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else if (i_hold) begin
            r_stage.valid <= r_stage.valid & ~w_kill;
        end else begin
            r_stage.valid <= i_load_valid;
            r_stage.cnt   <= i_load_cnt;
            r_stage.pack  <= i_load_pack;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_replay_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_replay_pipe
// Description : DEPTH-stage replay delay line between the memory issue select
//               stage and the AGU replay mux. Optional build macro
//               FALCO_REPLAY_DEPEND_SQUASH_EN drops the incoming packet when
//               load_depend_replay is raised outside a hold.
// Revision    : 1.0
// ============================================================================
module mem_replay_pipe
    import mem_replay_pipe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  branch_flush_t                 recovery_flush_BCAST,
    input  logic                          recovery_stall,
    input  logic                          load_wake_up_failed_stall,
    input  logic                          replay_muldiv_stall,
    input  logic                          load_depend_replay,
    input  logic                          issue_instr_valid,
    input  mem_dispatch_pack_t            issue_instr_pack,
    input  logic                          issue_is_replay,
    input  logic [REPLAY_CNT_W-1:0]       issue_replay_cnt,
    output logic                          replay_issue_instr_valid,
    output mem_dispatch_pack_t            replay_issue_instr_pack,
    output logic [REPLAY_CNT_W-1:0]       replay_issue_cnt,
    output logic                          replay_limit_hit,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    replay_stage_t               w_stage [DEPTH];
    logic [DEPTH-1:0]            w_valid;
    logic                        w_hold;
    logic                        w_squash;
    logic                        w_in_valid;
    logic [REPLAY_CNT_W-1:0]     w_in_cnt;

    assign w_hold = recovery_stall | load_wake_up_failed_stall | replay_muldiv_stall;

`ifdef FALCO_REPLAY_DEPEND_SQUASH_EN
    assign w_squash = load_depend_replay;
`else
    logic w_unused_load_depend;
    assign w_unused_load_depend = load_depend_replay;
    assign w_squash             = 1'b0;
`endif

    assign w_in_valid = issue_instr_valid
                      & ~IsBrROBKill(recovery_flush_BCAST, issue_instr_pack.rob_tag)
                      & ~w_squash;
    assign w_in_cnt   = next_replay_cnt(issue_is_replay, issue_replay_cnt);

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic                    w_ld_valid;
            logic [REPLAY_CNT_W-1:0] w_ld_cnt;
            mem_dispatch_pack_t      w_ld_pack;

            if (i == 0) begin : g_head
                assign w_ld_valid = w_in_valid;
                assign w_ld_cnt   = w_in_cnt;
                assign w_ld_pack  = issue_instr_pack;
            end else begin : g_body
                // Kill applies to the packet as it moves, not just where it lands.
                assign w_ld_valid = w_stage[i-1].valid
                                  & ~IsBrROBKill(recovery_flush_BCAST, w_stage[i-1].pack.rob_tag);
                assign w_ld_cnt   = w_stage[i-1].cnt;
                assign w_ld_pack  = w_stage[i-1].pack;
            end

            mem_replay_stage u_stage (
                .clk          (clk),
                .rst          (rst),
                .i_flush      (recovery_flush_BCAST),
                .i_hold       (w_hold),
                .i_load_valid (w_ld_valid),
                .i_load_cnt   (w_ld_cnt),
                .i_load_pack  (w_ld_pack),
                .o_stage      (w_stage[i])
            );

            assign w_valid[i] = w_stage[i].valid;
        end
    endgenerate

    assign replay_issue_instr_valid = w_stage[DEPTH-1].valid;
    assign replay_issue_instr_pack  = w_stage[DEPTH-1].pack;
    assign replay_issue_cnt         = w_stage[DEPTH-1].cnt;
    assign replay_limit_hit         = w_stage[DEPTH-1].valid & (&w_stage[DEPTH-1].cnt);

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(w_valid[i]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_replay_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_replay_pipe
// Description : Drives DEPTH=1,2,3 instances of mem_replay_pipe with shared
//               directed stimulus and checks them against a packet-list model.
// Revision    : 1.0
// ============================================================================
module tb_mem_replay_pipe;
    import mem_replay_pipe_pkg::*;

`ifdef FALCO_REPLAY_DEPEND_SQUASH_EN
    localparam bit SQ = 1'b1;
`else
    localparam bit SQ = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                fl_valid = 1'b0;
    logic [15:0]         fl_mask = '0;
    logic                rstall = 1'b0, wkstall = 1'b0, mdstall = 1'b0, ldr = 1'b0;
    logic                iv = 1'b0, isrep = 1'b0;
    logic [2:0]          rcnt = '0;
    mem_dispatch_pack_t  ipack = '0;
    branch_flush_t       flush;

    logic        o_v   [3];
    logic [31:0] o_pk  [3];
    logic [31:0] o_c   [3];
    logic        o_lim [3];
    logic [31:0] o_occ [3];

    int total = 0;
    int bad   = 0;

    assign flush.valid     = fl_valid;
    assign flush.kill_mask = fl_mask;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int D  = g + 1;
            localparam int OW = $clog2(D + 1);
            logic               v, lim;
            mem_dispatch_pack_t pk;
            logic [2:0]         c;
            logic [OW-1:0]      occ;

            mem_replay_pipe #(.DEPTH(D)) u_dut (
                .clk                       (clk),
                .rst                       (rst),
                .recovery_flush_BCAST      (flush),
                .recovery_stall            (rstall),
                .load_wake_up_failed_stall (wkstall),
                .replay_muldiv_stall       (mdstall),
                .load_depend_replay        (ldr),
                .issue_instr_valid         (iv),
                .issue_instr_pack          (ipack),
                .issue_is_replay           (isrep),
                .issue_replay_cnt          (rcnt),
                .replay_issue_instr_valid  (v),
                .replay_issue_instr_pack   (pk),
                .replay_issue_cnt          (c),
                .replay_limit_hit          (lim),
                .occupancy                 (occ)
            );

            assign o_v[g]   = v;
            assign o_pk[g]  = 32'(pk);
            assign o_c[g]   = 32'(c);
            assign o_lim[g] = lim;
            assign o_occ[g] = 32'(occ);
        end
    endgenerate

    // Model: a list of in-flight packets, each knowing its instance and how
    // many unheld edges it has survived since capture.
    typedef struct {
        int                 inst;
        int                 age;
        logic [2:0]         cnt;
        mem_dispatch_pack_t pack;
    } rec_t;

    rec_t q[$];

    function automatic bit killed(input logic [3:0] tag);
        return fl_valid && fl_mask[tag];
    endfunction

    always @(posedge clk or posedge rst) begin : m_upd
        rec_t nq[$];
        rec_t r;
        bit   hold;
        if (rst) begin
            q.delete();
        end else begin
            nq.delete();
            hold = rstall || wkstall || mdstall;
            foreach (q[j]) begin
                r = q[j];
                if (!killed(r.pack.rob_tag)) begin
                    if (!hold) r.age = r.age + 1;
                    if (r.age < r.inst + 1) nq.push_back(r);
                end
            end
            if (!hold && iv && !killed(ipack.rob_tag) && !(SQ && ldr)) begin
                for (int k = 0; k < 3; k++) begin
                    r.inst = k;
                    r.age  = 0;
                    r.pack = ipack;
                    r.cnt  = !isrep ? 3'd0 : (rcnt == 3'd7 ? 3'd7 : rcnt + 3'd1);
                    nq.push_back(r);
                end
            end
            q = nq;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            bit          ev;
            logic [31:0] ecnt, epk, eocc;
            ev = 0; ecnt = 0; epk = 0; eocc = 0;
            foreach (q[j]) begin
                if (q[j].inst == k) begin
                    eocc++;
                    if (q[j].age == k) begin
                        ev   = 1;
                        ecnt = 32'(q[j].cnt);
                        epk  = 32'(q[j].pack);
                    end
                end
            end
            chk($sformatf("model_valid_d%0d", k + 1), 32'(o_v[k]), 32'(ev));
            if (ev) begin
                chk($sformatf("model_pack_d%0d", k + 1), o_pk[k], epk);
                chk($sformatf("model_cnt_d%0d", k + 1), o_c[k], ecnt);
            end
            chk($sformatf("model_limit_d%0d", k + 1), 32'(o_lim[k]), 32'(ev && ecnt == 7));
            chk($sformatf("model_occ_d%0d", k + 1), o_occ[k], eocc);
        end
    endtask

    function automatic mem_dispatch_pack_t mk(input logic [3:0] t);
        mem_dispatch_pack_t p;
        p.rob_tag = t;
        p.op      = mem_op_e'(t[1:0]);
        p.prd     = 5'(t) + 5'd1;
        p.imm     = 16'(t) * 16'd100;
        return p;
    endfunction

    task automatic tick();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [3:0] tag, input logic rp, input logic [2:0] rc);
        iv    = v;
        ipack = mk(tag);
        isrep = rp;
        rcnt  = rc;
    endtask

    task automatic drain(input int n);
        drive(1'b0, 4'd0, 1'b0, 3'd0);
        repeat (n) tick();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_valid", 32'(o_v[k]), 32'd0);
            chk("reset_pack", o_pk[k], 32'd0);
            chk("reset_cnt", o_c[k], 32'd0);
            chk("reset_occ", o_occ[k], 32'd0);
        end
        rst = 1'b0;

        // Plain issue, latency DEPTH
        drive(1'b1, 4'd5, 1'b0, 3'd0);
        tick();
        chk("d2_occ_t1", o_occ[1], 32'd1);
        chk("d2_valid_t1", 32'(o_v[1]), 32'd0);
        drive(1'b0, 4'd0, 1'b0, 3'd0);
        tick();
        chk("d2_valid_t2", 32'(o_v[1]), 32'd1);
        chk("d2_tag_t2", 32'(o_pk[1][26:23]), 32'd5);
        chk("d2_cnt_t2", o_c[1], 32'd0);
        chk("d2_occ_t2", o_occ[1], 32'd1);
        drain(2);

        // Replay counter increment and saturation
        drive(1'b1, 4'd3, 1'b1, 3'd6);
        tick();
        drain(1);
        chk("d2_cnt_from6", o_c[1], 32'd7);
        chk("d2_limit_from6", 32'(o_lim[1]), 32'd1);
        drive(1'b1, 4'd4, 1'b1, 3'd7);
        tick();
        drain(1);
        chk("d2_cnt_from7", o_c[1], 32'd7);
        drain(2);

        // Back-to-back then recovery_stall; issue during hold is dropped
        for (int t = 1; t <= 3; t++) begin
            drive(1'b1, 4'(t), 1'b0, 3'd0);
            tick();
        end
        rstall = 1'b1;
        drive(1'b1, 4'd7, 1'b0, 3'd0);
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("d3_hold_tag", 32'(o_pk[2][26:23]), 32'd1);
            chk("d3_hold_occ", o_occ[2], 32'd3);
        end
        rstall = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 3'd0);
        tick();
        chk("d3_drain_tag2", 32'(o_pk[2][26:23]), 32'd2);
        tick();
        chk("d3_drain_tag3", 32'(o_pk[2][26:23]), 32'd3);
        drain(2);

        // Kill tag 9 in s[0] under muldiv stall
        drive(1'b1, 4'd8, 1'b0, 3'd0); tick();
        drive(1'b1, 4'd9, 1'b0, 3'd0); tick();
        drive(1'b0, 4'd0, 1'b0, 3'd0);
        mdstall  = 1'b1;
        fl_valid = 1'b1;
        fl_mask  = 16'h0200;
        tick();
        chk("d3_kill_hold_occ", o_occ[2], 32'd1);
        fl_valid = 1'b0;
        tick();
        mdstall = 1'b0;
        tick();
        chk("d3_kill_hold_tag8", 32'(o_pk[2][26:23]), 32'd8);
        drain(3);

        // Kill tag 9 while it shifts, no stall; then kill the incoming packet
        drive(1'b1, 4'd8, 1'b0, 3'd0); tick();
        drive(1'b1, 4'd9, 1'b0, 3'd0); tick();
        drive(1'b1, 4'd10, 1'b0, 3'd0);
        fl_valid = 1'b1;
        tick();
        chk("d3_kill_run_occ", o_occ[2], 32'd2);
        chk("d3_kill_run_tag8", 32'(o_pk[2][26:23]), 32'd8);
        fl_valid = 1'b0;
        drain(1);
        chk("d3_kill_run_gap", 32'(o_v[2]), 32'd0);
        tick();
        chk("d3_kill_run_tag10", 32'(o_pk[2][26:23]), 32'd10);
        drain(1);
        drive(1'b1, 4'd9, 1'b0, 3'd0);
        fl_valid = 1'b1;
        tick();
        chk("d1_kill_incoming_occ", o_occ[0], 32'd0);
        fl_valid = 1'b0;
        drain(3);

        // load_depend_replay outside hold, then under hold
        ldr = 1'b1;
        drive(1'b1, 4'd6, 1'b0, 3'd0);
        tick();
        ldr = 1'b0;
        drain(1);
        chk("d2_ldr_valid", 32'(o_v[1]), SQ ? 32'd0 : 32'd1);
        drain(2);
        drive(1'b1, 4'd11, 1'b0, 3'd0);
        tick();
        drive(1'b0, 4'd0, 1'b0, 3'd0);
        ldr     = 1'b1;
        wkstall = 1'b1;
        tick();
        chk("d1_ldr_hold_occ", o_occ[0], 32'd1);
        ldr     = 1'b0;
        wkstall = 1'b0;
        drain(3);

        // Asynchronous reset between edges
        drive(1'b1, 4'd12, 1'b0, 3'd0); tick();
        drive(1'b1, 4'd13, 1'b0, 3'd0); tick();
        chk("d3_pre_reset_occ", o_occ[2], 32'd2);
        drive(1'b0, 4'd0, 1'b0, 3'd0);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("async_rst_valid", 32'(o_v[k]), 32'd0);
            chk("async_rst_occ", o_occ[k], 32'd0);
            chk("async_rst_pack", o_pk[k], 32'd0);
            chk("async_rst_limit", 32'(o_lim[k]), 32'd0);
        end
        tick();
        rst = 1'b0;
        drive(1'b1, 4'd14, 1'b0, 3'd0);
        tick();
        chk("d1_after_rst_tag", 32'(o_pk[0][26:23]), 32'd14);
        chk("d1_after_rst_valid", 32'(o_v[0]), 32'd1);
        drain(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
